sccb_clk_gen: RTL and testbench

Parametrised, runtime-programmable SCCB bit-clock generator for the camera control path. It produces an idle-high SIO_C waveform and single-cycle phase strobes (fall, low-mid, rise, high-mid) so the SCCB master FSM can change SIO_D at low-mid and sample it at high-mid. The divisor is loaded at run time, and start/stop are clean on period boundaries. The block sits between the PCLK domain and the SCCB master, and is fed by the APB-programmed divisor register.

---
 rtl/sccb_clk_gen.sv | 212 +++++++++++++++++++++
 tb/tb_sccb_clk_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_clk_gen.sv
// sccb_clk_gen: runtime-programmable SCCB bit-clock generator.
// Produces an idle-high SIO_C level and one-cycle phase strobes (fall,
// low-mid, rise, high-mid, stop) for the SCCB master FSM. The master
// changes SIO_D on LOW_MID_PULSE and samples it on HIGH_MID_PULSE.
//
// Optional build macro: SCCB_CLK_STRETCH_EN
//   When defined, an SCL_IN port is added. It is synchronised by two PCLK
//   flops, and the HIGH phase pauses while the synchronised line reads low
//   (slave clock stretching). When undefined, HIGH is always exactly Hq
//   cycles and neither the port nor the synchroniser exists.
//
// Every output comes straight from a flop. Next-cycle values are computed
// combinationally from the next state, so each strobe lines up with the
// first cycle of the phase it marks.
`timescale 1ns/1ps

module sccb_clk_gen #(
  parameter int CNT_W    = 16,
  parameter int HALF_MIN = 2
) (
  input  logic             PCLK,
  input  logic             PRESETN,
  input  logic             EN,
  input  logic [CNT_W-1:0] HALF_PERIOD,
`ifdef SCCB_CLK_STRETCH_EN
  input  logic             SCL_IN,
`endif
  output logic             SCL_OUT,
  output logic             FALL_PULSE,
  output logic             LOW_MID_PULSE,
  output logic             RISE_PULSE,
  output logic             HIGH_MID_PULSE,
  output logic             STOP_PULSE,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_HALF_MIN = CNT_W'(HALF_MIN);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  // Phase state, phase-cycle counter and the half-period latched for the
  // current period.
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hq;

  // Registered outputs.
  logic r_scl;
  logic r_fall;
  logic r_low_mid;
  logic r_rise;
  logic r_high_mid;
  logic r_stop;
  logic r_busy;

  // Combinational next-cycle values.
  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_hq_next;
  logic [CNT_W-1:0] w_hp_clamped;
  logic [CNT_W-1:0] w_hq_last;
  logic [CNT_W-1:0] w_mid_next;
  logic             w_phase_end;
  logic             w_advance;
  logic             w_scl_next;
  logic             w_fall_next;
  logic             w_low_mid_next;
  logic             w_rise_next;
  logic             w_high_mid_next;
  logic             w_stop_next;
  logic             w_busy_next;

`ifdef SCCB_CLK_STRETCH_EN
  // Two-flop synchroniser for the externally observed SIO_C line. Both
  // flops reset to 1 because an idle bus reads high, which keeps the
  // first HIGH phase after reset from being stretched by accident.
  logic r_scl_sync1;
  logic r_scl_sync2;

  // Bring SCL_IN into the PCLK domain.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_scl_sync1 <= 1'b1;
      r_scl_sync2 <= 1'b1;
    end else begin
      r_scl_sync1 <= SCL_IN;
      r_scl_sync2 <= r_scl_sync1;
    end
  end

  // HIGH advances only while the line is actually seen high.
  assign w_advance = r_scl_sync2;
`else
  // Without stretching, HIGH always advances.
  assign w_advance = 1'b1;
`endif

  // Clamp the programmed half-period so that both mid strobes stay clear
  // of the edge strobes.
  assign w_hp_clamped = (HALF_PERIOD < C_HALF_MIN) ? C_HALF_MIN : HALF_PERIOD;
  assign w_hq_last    = r_hq - C_ONE;
  assign w_phase_end  = (r_cnt == w_hq_last);

  // Next-state logic. EN is examined in IDLE and at the end of HIGH only,
  // so a period that has started always runs to completion.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hq_next    = r_hq;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (EN) begin
          w_state_next = ST_LOW;
          w_hq_next    = w_hp_clamped;
        end
      end
      ST_LOW: begin
        if (w_phase_end) begin
          w_state_next = ST_HIGH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + C_ONE;
        end
      end
      ST_HIGH: begin
        if (w_advance) begin
          if (w_phase_end) begin
            w_cnt_next = '0;
            if (EN) begin
              // A new period picks up the divisor currently programmed.
              w_state_next = ST_LOW;
              w_hq_next    = w_hp_clamped;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_cnt_next = r_cnt + C_ONE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so the
  // registered strobes mark phase cycle 0 and phase cycle floor(Hq/2).
  always_comb begin
    w_mid_next      = w_hq_next >> 1;
    w_scl_next      = (w_state_next != ST_LOW);
    w_fall_next     = (w_state_next == ST_LOW)  && (r_state != ST_LOW);
    w_rise_next     = (w_state_next == ST_HIGH) && (r_state == ST_LOW);
    w_low_mid_next  = (w_state_next == ST_LOW)  && (w_cnt_next == w_mid_next);
    // A stalled HIGH holds cnt, so gating with w_advance keeps the
    // high-mid strobe one cycle wide even if a stall lands on it.
    w_high_mid_next = (w_state_next == ST_HIGH) && (r_state == ST_HIGH) &&
                      w_advance && (w_cnt_next == w_mid_next);
    w_stop_next     = (w_state_next == ST_IDLE) && (r_state == ST_HIGH);
    w_busy_next     = (w_state_next != ST_IDLE);
  end

  // State, counter and latched half-period registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hq    <= C_HALF_MIN;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hq    <= w_hq_next;
    end
  end

  // Output registers; reset forces an idle-high line with no strobes.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_scl      <= 1'b1;
      r_fall     <= 1'b0;
      r_low_mid  <= 1'b0;
      r_rise     <= 1'b0;
      r_high_mid <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_scl      <= w_scl_next;
      r_fall     <= w_fall_next;
      r_low_mid  <= w_low_mid_next;
      r_rise     <= w_rise_next;
      r_high_mid <= w_high_mid_next;
      r_stop     <= w_stop_next;
      r_busy     <= w_busy_next;
    end
  end

  assign SCL_OUT        = r_scl;
  assign FALL_PULSE     = r_fall;
  assign LOW_MID_PULSE  = r_low_mid;
  assign RISE_PULSE     = r_rise;
  assign HIGH_MID_PULSE = r_high_mid;
  assign STOP_PULSE     = r_stop;
  assign BUSY           = r_busy;

endmodule

// File: tb/tb_sccb_clk_gen.sv
// tb_sccb_clk_gen: scoreboard bench for sccb_clk_gen.
// Each scenario pushes its hand-computed strobe events (kind + cycle) into
// a queue; a monitor pops and compares whenever any strobe is active.
`timescale 1ns/1ps

module tb_sccb_clk_gen;

  localparam int CNT_W = 16;

  localparam int M_FALL = 1;
  localparam int M_LM   = 2;
  localparam int M_RISE = 4;
  localparam int M_HM   = 8;
  localparam int M_STOP = 16;

  logic             PCLK = 1'b0;
  logic             PRESETN;
  logic             EN;
  logic [CNT_W-1:0] HALF_PERIOD;
`ifdef SCCB_CLK_STRETCH_EN
  logic             SCL_IN;
`endif
  logic             SCL_OUT;
  logic             FALL_PULSE;
  logic             LOW_MID_PULSE;
  logic             RISE_PULSE;
  logic             HIGH_MID_PULSE;
  logic             STOP_PULSE;
  logic             BUSY;

  typedef struct {
    int mask;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_err = 0;

  sccb_clk_gen #(.CNT_W(CNT_W), .HALF_MIN(2)) dut (
    .PCLK           (PCLK),
    .PRESETN        (PRESETN),
    .EN             (EN),
    .HALF_PERIOD    (HALF_PERIOD),
`ifdef SCCB_CLK_STRETCH_EN
    .SCL_IN         (SCL_IN),
`endif
    .SCL_OUT        (SCL_OUT),
    .FALL_PULSE     (FALL_PULSE),
    .LOW_MID_PULSE  (LOW_MID_PULSE),
    .RISE_PULSE     (RISE_PULSE),
    .HIGH_MID_PULSE (HIGH_MID_PULSE),
    .STOP_PULSE     (STOP_PULSE),
    .BUSY           (BUSY)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  function automatic int strobe_mask();
    int m;
    m = 0;
    if (FALL_PULSE)     m = m | M_FALL;
    if (LOW_MID_PULSE)  m = m | M_LM;
    if (RISE_PULSE)     m = m | M_RISE;
    if (HIGH_MID_PULSE) m = m | M_HM;
    if (STOP_PULSE)     m = m | M_STOP;
    return m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int mask, input int c);
    ev_t e;
    e.mask = mask;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge PCLK);
  endtask

  task automatic check_levels(input string name, input int scl, input int busy);
    check({name, "_scl"}, int'(SCL_OUT), scl);
    check({name, "_busy"}, int'(BUSY), busy);
  endtask

  // Monitor: every cycle with an active strobe is one transaction.
  always @(negedge PCLK) begin
    int m;
    ev_t e;
    m = strobe_mask();
    if (m != 0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_strobe: got mask %0d expected none (cycle %0d)", m, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("cycle %0d strobe mask=%0d (expected mask=%0d at cycle %0d)", cyc, m, e.mask, e.cyc);
        check("strobe_mask", m, e.mask);
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  // Watchdog against a stalled run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    PRESETN     = 1'b0;
    EN          = 1'b0;
    HALF_PERIOD = 16'd50;
`ifdef SCCB_CLK_STRETCH_EN
    SCL_IN      = 1'b1;
`endif
    repeat (3) @(negedge PCLK);
    check_levels("reset", 1, 0);
    check("reset_strobes", strobe_mask(), 0);
    PRESETN = 1'b1;
    repeat (2) @(negedge PCLK);
    check_levels("idle", 1, 0);

    // H=50: 100-cycle period, two periods, EN dropped in the second LOW.
    c = cyc;
    push(M_FALL, c + 1);   push(M_LM, c + 26);  push(M_RISE, c + 51);  push(M_HM, c + 76);
    push(M_FALL, c + 101); push(M_LM, c + 126); push(M_RISE, c + 151); push(M_HM, c + 176);
    push(M_STOP, c + 201);
    HALF_PERIOD = 16'd50;
    EN = 1'b1;
    wait_cyc(c + 1);   check_levels("h50_low", 0, 1);
    wait_cyc(c + 51);  check_levels("h50_high", 1, 1);
    wait_cyc(c + 110); EN = 1'b0;
    wait_cyc(c + 201); check_levels("h50_stop", 1, 0);
    wait_cyc(c + 205);

    // HALF_PERIOD 0 then 1, both clamped to 2; restart in the STOP cycle.
    c = cyc;
    push(M_FALL, c + 1);  push(M_LM, c + 2);   push(M_RISE, c + 3);  push(M_HM, c + 4);
    push(M_FALL, c + 5);  push(M_LM, c + 6);   push(M_RISE, c + 7);  push(M_HM, c + 8);
    push(M_STOP, c + 9);
    push(M_FALL, c + 10); push(M_LM, c + 11);  push(M_RISE, c + 12); push(M_HM, c + 13);
    push(M_STOP, c + 14);
    HALF_PERIOD = 16'd0;
    EN = 1'b1;
    wait_cyc(c + 2);  HALF_PERIOD = 16'd1;
    wait_cyc(c + 6);  EN = 1'b0;
    wait_cyc(c + 9);  check_levels("min_stop", 1, 0); EN = 1'b1;
    wait_cyc(c + 10); check_levels("min_restart", 0, 1);
    wait_cyc(c + 11); EN = 1'b0;
    wait_cyc(c + 14); check_levels("min_stop2", 1, 0);
    wait_cyc(c + 18);

    // H=10, EN dropped in LOW cycle 3: period completes, STOP 20 after FALL.
    c = cyc;
    push(M_FALL, c + 1); push(M_LM, c + 6); push(M_RISE, c + 11); push(M_HM, c + 16);
    push(M_STOP, c + 21);
    HALF_PERIOD = 16'd10;
    EN = 1'b1;
    wait_cyc(c + 4);  EN = 1'b0;
    wait_cyc(c + 15); check_levels("drop_high", 1, 1);
    wait_cyc(c + 21); check_levels("drop_stop", 1, 0);
    wait_cyc(c + 23); check_levels("drop_idle", 1, 0);

    // HALF_PERIOD 50 -> 20 mid-HIGH: current period 100, next 40.
    c = cyc;
    push(M_FALL, c + 1);   push(M_LM, c + 26);  push(M_RISE, c + 51);  push(M_HM, c + 76);
    push(M_FALL, c + 101); push(M_LM, c + 111); push(M_RISE, c + 121); push(M_HM, c + 131);
    push(M_FALL, c + 141); push(M_LM, c + 151); push(M_RISE, c + 161); push(M_HM, c + 171);
    push(M_STOP, c + 181);
    HALF_PERIOD = 16'd50;
    EN = 1'b1;
    wait_cyc(c + 60);  HALF_PERIOD = 16'd20;
    wait_cyc(c + 150); EN = 1'b0;
    wait_cyc(c + 185);

    // Reset pulsed while LOW_MID is high; restart 1 cycle after release.
    c = cyc;
    push(M_FALL, c + 1);
    HALF_PERIOD = 16'd10;
    EN = 1'b1;
    wait_cyc(c + 5);
    @(posedge PCLK);
    #2;
    PRESETN = 1'b0;
    #1;
    check_levels("async_rst", 1, 0);
    check("async_rst_strobes", strobe_mask(), 0);
    push(M_FALL, c + 9); push(M_LM, c + 14); push(M_RISE, c + 19); push(M_HM, c + 24);
    push(M_STOP, c + 29);
    wait_cyc(c + 8);  PRESETN = 1'b1;
    wait_cyc(c + 9);  check_levels("rst_restart", 0, 1);
    wait_cyc(c + 12); EN = 1'b0;
    wait_cyc(c + 32);

`ifdef SCCB_CLK_STRETCH_EN
    // H=50, SCL_IN low for 30 cycles from HIGH cycle 5: HIGH stretched by 30.
    c = cyc;
    push(M_FALL, c + 1); push(M_LM, c + 26); push(M_RISE, c + 51); push(M_HM, c + 106);
    push(M_STOP, c + 131);
    HALF_PERIOD = 16'd50;
    EN = 1'b1;
    wait_cyc(c + 54);  SCL_IN = 1'b0;
    wait_cyc(c + 60);  EN = 1'b0;
    wait_cyc(c + 84);  SCL_IN = 1'b1;
    wait_cyc(c + 100); check_levels("stretch_high", 1, 1);
    wait_cyc(c + 131); check_levels("stretch_stop", 1, 0);
    wait_cyc(c + 135);
`endif

    repeat (4) @(negedge PCLK);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
